// File: rtl/mpc_kob.sv
// Per-channel keep-order buffer: reorders tagged bank load responses into allocation order.
// Optional same-cycle head bypass is enabled by defining MPC_KOB_BYPASS_EN.
module mpc_kob #(
  parameter int         KOB_SIZE   = 8,
  parameter logic [1:0] CHANNEL_ID = 2'd0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         alloc_valid_i,
  output logic         alloc_ready_o,
  output logic [2:0]   alloc_rob_id_o,
  input  logic         rsp_valid_i,
  input  logic [132:0] rsp_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_rsp_o,
  output logic [3:0]   occupancy_o,
  output logic         err_o
);
  localparam int ROB_W = $clog2(KOB_SIZE);
  localparam int PW    = ROB_W + 1;

  typedef struct packed {
    logic [1:0]   channel_id;
    logic [2:0]   rob_id;
    logic [127:0] rdata;
  } rc_rsp_t;

  rc_rsp_t rsp;
  assign rsp = rc_rsp_t'(rsp_i);

  logic [PW-1:0]                     head_q, head_d, tail_q, tail_d;
  logic [KOB_SIZE-1:0]               pend_q, pend_d, fill_q, fill_d;
  logic [KOB_SIZE-1:0][127:0]        data_q, data_d;
  logic                              err_q, err_d;

  logic [ROB_W-1:0] hidx, tidx, ridx;
  logic             full, alloc_fire, rsp_legal, vld_reg, pop;

  assign hidx = head_q[ROB_W-1:0];
  assign tidx = tail_q[ROB_W-1:0];
  assign ridx = rsp.rob_id[ROB_W-1:0];

  // Same index with differing wrap bits means every slot is allocated.
  assign full       = (hidx == tidx) && (head_q[ROB_W] != tail_q[ROB_W]);
  assign alloc_fire = alloc_valid_i && !full;

  assign rsp_legal = rsp_valid_i && (rsp.channel_id == CHANNEL_ID) &&
                     (32'(rsp.rob_id) < KOB_SIZE) && pend_q[ridx] && !fill_q[ridx];

  assign vld_reg = pend_q[hidx] & fill_q[hidx];

`ifdef MPC_KOB_BYPASS_EN
  logic byp_hit;
  // A legal hit on the head slot implies fill[head]=0, so it is forwarded straight out.
  assign byp_hit = rsp_legal && (ridx == hidx);

  always_comb begin
    out_valid_o = vld_reg | byp_hit;
    out_rsp_o   = '0;
    if (vld_reg)      out_rsp_o = data_q[hidx];
    else if (byp_hit) out_rsp_o = rsp.rdata;
  end
`else
  always_comb begin
    out_valid_o = vld_reg;
    out_rsp_o   = vld_reg ? data_q[hidx] : '0;
  end
`endif

  assign pop = out_valid_o && out_ready_i;

  assign alloc_ready_o  = !full;
  assign alloc_rob_id_o = 3'(tidx);
  assign occupancy_o    = 4'(tail_q - head_q);
  assign err_o          = err_q;

  // Pop is applied last so a bypassed head fill in the same cycle leaves the slot clear.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    pend_d = pend_q;
    fill_d = fill_q;
    data_d = data_q;
    err_d  = err_q;
    if (alloc_fire) begin
      pend_d[tidx] = 1'b1;
      fill_d[tidx] = 1'b0;
      tail_d       = tail_q + PW'(1);
    end
    if (rsp_legal) begin
      fill_d[ridx] = 1'b1;
      data_d[ridx] = rsp.rdata;
    end else if (rsp_valid_i) begin
      err_d = 1'b1;
    end
    if (pop) begin
      pend_d[hidx] = 1'b0;
      fill_d[hidx] = 1'b0;
      head_d       = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      pend_q <= '0;
      fill_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      pend_q <= pend_d;
      fill_q <= fill_d;
      err_q  <= err_d;
    end
  end

  // Payload storage is never observed without its fill bit, so it needs no reset.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end
endmodule

// File: tb/tb_mpc_kob.sv
// Directed bench for mpc_kob (KOB_SIZE=8, CHANNEL_ID=0); one task per scenario.
module tb_mpc_kob;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         alloc_valid_i = 1'b0;
  logic         alloc_ready_o;
  logic [2:0]   alloc_rob_id_o;
  logic         rsp_valid_i = 1'b0;
  logic [132:0] rsp_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [127:0] out_rsp_o;
  logic [3:0]   occupancy_o;
  logic         err_o;

  int total = 0;
  int bad   = 0;

  mpc_kob #(.KOB_SIZE(8), .CHANNEL_ID(2'd0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_rob_id_o(alloc_rob_id_o),
    .rsp_valid_i(rsp_valid_i), .rsp_i(rsp_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rsp_o(out_rsp_o),
    .occupancy_o(occupancy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    alloc_valid_i = 1'b0; rsp_valid_i = 1'b0; out_ready_i = 1'b0; rsp_i = '0;
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic alloc_n(input int n);
    alloc_valid_i = 1'b1;
    repeat (n) tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic send_rsp(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] d);
    rsp_valid_i = 1'b1;
    rsp_i = {ch, rob, d};
    tick();
    rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_o); end
    total++; if (out_rsp_o !== 128'h0) begin bad++; $display("FAIL rst_out_rsp got=%h exp=0", out_rsp_o); end
    total++; if (occupancy_o !== 4'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy_o); end
    total++; if (alloc_ready_o !== 1'b1) begin bad++; $display("FAIL rst_alloc_ready got=%b exp=1", alloc_ready_o); end
    total++; if (alloc_rob_id_o !== 3'd0) begin bad++; $display("FAIL rst_rob_id got=%0d exp=0", alloc_rob_id_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
  endtask

  task automatic test_in_order();
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (alloc_rob_id_o !== 3'(i)) begin bad++; $display("FAIL io_rob_id got=%0d exp=%0d", alloc_rob_id_o, i); end
      alloc_n(1);
    end
    total++; if (occupancy_o !== 4'd3) begin bad++; $display("FAIL io_occ3 got=%0d exp=3", occupancy_o); end
    for (int i = 0; i < 3; i++) begin
      rsp_valid_i = 1'b1;
      rsp_i = {2'd0, 3'(i), 128'hA0 + 128'(i)};
      tick();
      total++; if (out_valid_o !== 1'b1 || out_rsp_o !== 128'hA0 + 128'(i)) begin
        bad++; $display("FAIL io_out%0d got=%b/%h exp=1/%h", i, out_valid_o, out_rsp_o, 128'hA0 + 128'(i)); end
    end
    rsp_valid_i = 1'b0;
    tick();
    total++; if (occupancy_o !== 4'd0 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL io_drain got=%0d/%b exp=0/0", occupancy_o, out_valid_o); end
  endtask

  task automatic test_reorder();
    logic [2:0] order [4] = '{3'd3, 3'd1, 3'd2, 3'd0};
    do_reset();
    out_ready_i = 1'b1;
    alloc_n(4);
    for (int k = 0; k < 3; k++) begin
      send_rsp(2'd0, order[k], 128'hB0 + 128'(order[k]));
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL ro_early%0d got=%b exp=0", k, out_valid_o); end
    end
    send_rsp(2'd0, 3'd0, 128'hB0);
    for (int k = 0; k < 4; k++) begin
      total++; if (out_valid_o !== 1'b1 || out_rsp_o !== 128'hB0 + 128'(k)) begin
        bad++; $display("FAIL ro_out%0d got=%b/%h exp=1/%h", k, out_valid_o, out_rsp_o, 128'hB0 + 128'(k)); end
      tick();
    end
    total++; if (out_valid_o !== 1'b0 || occupancy_o !== 4'd0) begin
      bad++; $display("FAIL ro_drain got=%b/%0d exp=0/0", out_valid_o, occupancy_o); end
  endtask

  task automatic test_full();
    do_reset();
    alloc_n(8);
    total++; if (alloc_ready_o !== 1'b0 || occupancy_o !== 4'd8) begin
      bad++; $display("FAIL fu_full got=%b/%0d exp=0/8", alloc_ready_o, occupancy_o); end
    alloc_n(1);
    total++; if (occupancy_o !== 4'd8) begin bad++; $display("FAIL fu_blocked got=%0d exp=8", occupancy_o); end
    for (int i = 7; i >= 0; i--) send_rsp(2'd0, 3'(i), 128'hC0 + 128'(i));
    tick(); tick();
    total++; if (out_valid_o !== 1'b1 || out_rsp_o !== 128'hC0) begin
      bad++; $display("FAIL fu_hold got=%b/%h exp=1/c0", out_valid_o, out_rsp_o); end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    total++; if (alloc_ready_o !== 1'b1 || alloc_rob_id_o !== 3'd0 || occupancy_o !== 4'd7) begin
      bad++; $display("FAIL fu_pop got=%b/%0d/%0d exp=1/0/7", alloc_ready_o, alloc_rob_id_o, occupancy_o); end
    total++; if (out_rsp_o !== 128'hC1) begin bad++; $display("FAIL fu_next got=%h exp=c1", out_rsp_o); end
    alloc_n(1);
    total++; if (alloc_ready_o !== 1'b0 || occupancy_o !== 4'd8 || alloc_rob_id_o !== 3'd1) begin
      bad++; $display("FAIL fu_wrap got=%b/%0d/%0d exp=0/8/1", alloc_ready_o, occupancy_o, alloc_rob_id_o); end
  endtask

  task automatic test_stray();
    do_reset();
    alloc_n(2);
    send_rsp(2'd0, 3'd0, 128'hD1);
    total++; if (err_o !== 1'b0 || out_rsp_o !== 128'hD1) begin
      bad++; $display("FAIL st_legal got=%b/%h exp=0/d1", err_o, out_rsp_o); end
    send_rsp(2'd0, 3'd0, 128'hDEAD);
    total++; if (err_o !== 1'b1 || out_rsp_o !== 128'hD1) begin
      bad++; $display("FAIL st_dup got=%b/%h exp=1/d1", err_o, out_rsp_o); end
    send_rsp(2'd0, 3'd1, 128'hD2);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    total++; if (out_rsp_o !== 128'hD2 || err_o !== 1'b1) begin
      bad++; $display("FAIL st_order got=%h/%b exp=d2/1", out_rsp_o, err_o); end
    do_reset();
    alloc_n(1);
    send_rsp(2'd1, 3'd0, 128'hE9);
    total++; if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL st_chan got=%b/%b exp=1/0", err_o, out_valid_o); end
    tick();
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL st_sticky got=%b exp=1", err_o); end
    send_rsp(2'd0, 3'd0, 128'hE1);
    total++; if (out_valid_o !== 1'b1 || out_rsp_o !== 128'hE1) begin
      bad++; $display("FAIL st_after got=%b/%h exp=1/e1", out_valid_o, out_rsp_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(5);
    send_rsp(2'd0, 3'd0, 128'hF0);
    send_rsp(2'd0, 3'd1, 128'hF1);
    total++; if (occupancy_o !== 4'd5 || out_valid_o !== 1'b1) begin
      bad++; $display("FAIL rm_pre got=%0d/%b exp=5/1", occupancy_o, out_valid_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++; if (out_valid_o !== 1'b0 || out_rsp_o !== 128'h0 || occupancy_o !== 4'd0 ||
                 alloc_ready_o !== 1'b1 || alloc_rob_id_o !== 3'd0 || err_o !== 1'b0) begin
      bad++; $display("FAIL rm_vals got=%b/%h/%0d/%b/%0d/%b exp=0/0/0/1/0/0",
                      out_valid_o, out_rsp_o, occupancy_o, alloc_ready_o, alloc_rob_id_o, err_o); end
    send_rsp(2'd0, 3'd2, 128'hF2);
    total++; if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL rm_late got=%b/%b exp=1/0", err_o, out_valid_o); end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc_n(1);
    out_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    rsp_i = {2'd0, 3'd0, 128'h5A5A};
    #1;
`ifdef MPC_KOB_BYPASS_EN
    total++; if (out_valid_o !== 1'b1 || out_rsp_o !== 128'h5A5A) begin
      bad++; $display("FAIL by_same got=%b/%h exp=1/5a5a", out_valid_o, out_rsp_o); end
    tick();
    rsp_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b0 || occupancy_o !== 4'd0 || err_o !== 1'b0) begin
      bad++; $display("FAIL by_pop got=%b/%0d/%b exp=0/0/0", out_valid_o, occupancy_o, err_o); end
`else
    total++; if (out_valid_o !== 1'b0 || out_rsp_o !== 128'h0) begin
      bad++; $display("FAIL by_none got=%b/%h exp=0/0", out_valid_o, out_rsp_o); end
    tick();
    rsp_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b1 || out_rsp_o !== 128'h5A5A) begin
      bad++; $display("FAIL by_late got=%b/%h exp=1/5a5a", out_valid_o, out_rsp_o); end
    tick();
    total++; if (out_valid_o !== 1'b0 || occupancy_o !== 4'd0) begin
      bad++; $display("FAIL by_pop got=%b/%0d exp=0/0", out_valid_o, occupancy_o); end
`endif
    out_ready_i = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_in_order();
    test_reorder();
    test_full();
    test_stray();
    test_reset_mid();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
